// File: rtl/queue_event_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : queue_event_generator                                        |
// | Description : Turns two raw photocell inputs (front door = arrival, teller |
// |               door = departure) into clean, serialised up/down strobes for |
// |               an edge-triggered occupancy counter. Each sensor is          |
// |               synchronised, debounced and rising-edge detected; events are |
// |               held in pending flags and issued one at a time by an FSM     |
// |               that also keeps a saturating shadow occupancy count.         |
// | Ports       : clk           rising-edge system clock                       |
// |               reset         asynchronous, active-low reset                 |
// |               front_sensor  raw arrival photocell (1 = beam broken)        |
// |               back_sensor   raw departure photocell (1 = beam broken)      |
// |               up_pulse      registered increment strobe, PULSE_WIDTH wide  |
// |               down_pulse    registered decrement strobe, PULSE_WIDTH wide  |
// |               shadow_count  occupancy as tracked by this block             |
// |               full / empty  shadow_count at maximum / at zero              |
// |               drop_err      1-cycle strobe when an event is discarded      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module queue_event_generator #(
  parameter int COUNT_BITS      = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH     = 2,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  front_sensor,
  input  logic                  back_sensor,
  output logic                  up_pulse,
  output logic                  down_pulse,
  output logic [COUNT_BITS-1:0] shadow_count,
  output logic                  full,
  output logic                  empty,
  output logic                  drop_err
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX   = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
  localparam int TMR_W  = $clog2(TMAX + 1);
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UP_HI   = 2'd1,
    S_DOWN_HI = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  // Channel 0 = arrival (front), channel 1 = departure (back).
  logic [1:0] sensor_raw;
  logic [1:0] rise;

  assign sensor_raw = {back_sensor, front_sensor};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic              sync1_q;
    logic              sync2_q;
    logic              level_q;
    logic              level_d;
    logic              level_prev_q;
    logic [DCNT_W-1:0] dcnt_q;
    logic [DCNT_W-1:0] dcnt_d;

    // The level flips on the edge at which the mismatch run would reach
    // DEBOUNCE_CYCLES; the counter clears there because the level now matches.
    always_comb begin
      level_d = level_q;
      dcnt_d  = '0;
      if (sync2_q != level_q) begin
        if (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d = ~level_q;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        dcnt_q       <= '0;
      end else begin
        sync1_q      <= sensor_raw[g];
        sync2_q      <= sync1_q;
        level_q      <= level_d;
        level_prev_q <= level_q;
        dcnt_q       <= dcnt_d;
      end
    end

    assign rise[g] = level_q & ~level_prev_q;
  end

  state_t                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic                    arr_pend_q, arr_pend_d;
  logic                    dep_pend_q, dep_pend_d;
  logic                    up_q, up_d;
  logic                    down_q, down_d;
  logic                    drop_q, drop_d;
  logic                    dispatch;
  logic                    arr_clr;
  logic                    dep_clr;
  logic                    fsm_drop;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    count_d  = count_q;
    dispatch = 1'b0;
    arr_clr  = 1'b0;
    dep_clr  = 1'b0;
    fsm_drop = 1'b0;

    case (state_q)
      S_IDLE: dispatch = 1'b1;
      S_UP_HI, S_DOWN_HI: begin
        if (timer_q == TMR_W'(PULSE_WIDTH - 1)) begin
          state_d = S_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_GAP: begin
        // The last gap cycle dispatches directly so back-to-back events are
        // separated by exactly GAP_CYCLES low cycles, not GAP_CYCLES + 1.
        if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          dispatch = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Arrivals take priority; an event that would over/underflow is consumed
    // and reported rather than left pending.
    if (dispatch) begin
      if (arr_pend_q) begin
        arr_clr = 1'b1;
        if (count_q != COUNT_MAX) begin
          state_d = S_UP_HI;
          timer_d = '0;
          count_d = count_q + 1'b1;
        end else begin
          fsm_drop = 1'b1;
        end
      end else if (dep_pend_q) begin
        dep_clr = 1'b1;
        if (count_q != '0) begin
          state_d = S_DOWN_HI;
          timer_d = '0;
          count_d = count_q - 1'b1;
        end else begin
          fsm_drop = 1'b1;
        end
      end
    end

    // A new event landing on a flag that is being consumed this cycle is not
    // an overrun: the flag simply stays set for the new event.
    arr_pend_d = rise[0] | (arr_pend_q & ~arr_clr);
    dep_pend_d = rise[1] | (dep_pend_q & ~dep_clr);
    drop_d     = fsm_drop
               | (rise[0] & arr_pend_q & ~arr_clr)
               | (rise[1] & dep_pend_q & ~dep_clr);
    up_d       = (state_d == S_UP_HI);
    down_d     = (state_d == S_DOWN_HI);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      count_q    <= '0;
      arr_pend_q <= 1'b0;
      dep_pend_q <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      arr_pend_q <= arr_pend_d;
      dep_pend_q <= dep_pend_d;
      up_q       <= up_d;
      down_q     <= down_d;
      drop_q     <= drop_d;
    end
  end

  assign up_pulse     = up_q;
  assign down_pulse   = down_q;
  assign drop_err     = drop_q;
  assign shadow_count = count_q;
  assign full         = (count_q == COUNT_MAX);
  assign empty        = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_queue_event_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_queue_event_generator                                     |
// | Description : Self-checking bench for queue_event_generator. A timestamp-  |
// |               based reference model predicts every output each cycle;      |
// |               directed scenarios add explicit latency/count checks.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_queue_event_generator;

  localparam int CB   = 3;
  localparam int D    = 4;
  localparam int PW   = 2;
  localparam int GP   = 2;
  localparam int MAXC = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          front;
  logic          back;
  logic          up_pulse;
  logic          down_pulse;
  logic [CB-1:0] shadow_count;
  logic          full;
  logic          empty;
  logic          drop_err;

  always #5 clk = ~clk;

  queue_event_generator #(
    .COUNT_BITS      (CB),
    .DEBOUNCE_CYCLES (D),
    .PULSE_WIDTH     (PW),
    .GAP_CYCLES      (GP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .front_sensor (front),
    .back_sensor  (back),
    .up_pulse     (up_pulse),
    .down_pulse   (down_pulse),
    .shadow_count (shadow_count),
    .full         (full),
    .empty        (empty),
    .drop_err     (drop_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: synchroniser as a 2-deep delay, debounce as a mismatch
  // run length, and the pulse sequencer as timestamps (start of the last
  // pulse and earliest edge at which the next event may be issued).
  int cyc = 0;
  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  bit m_rose[2];
  bit m_pend[2];
  int m_run[2];
  int m_count;
  int m_next_ok;
  int m_up_start;
  int m_dn_start;
  bit m_drop;

  int tick_no  = 0;
  int first_up = -1;
  int first_dn = -1;
  int n_up     = 0;
  int n_dn     = 0;
  int n_drop   = 0;

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_s1[ch] = 0; m_s2[ch] = 0; m_lvl[ch] = 0;
      m_rose[ch] = 0; m_pend[ch] = 0; m_run[ch] = 0;
    end
    m_count    = 0;
    m_next_ok  = 0;
    m_up_start = -1000;
    m_dn_start = -1000;
    m_drop     = 0;
  endfunction

  function automatic void model_step(bit f, bit b);
    bit raw[2];
    bit clr[2];
    bit rise;
    raw[0] = f; raw[1] = b;
    clr[0] = 0; clr[1] = 0;
    m_drop = 0;
    cyc++;
    if (cyc >= m_next_ok) begin
      if (m_pend[0]) begin
        clr[0] = 1;
        if (m_count < MAXC) begin
          m_count++; m_up_start = cyc; m_next_ok = cyc + PW + GP;
        end else m_drop = 1;
      end else if (m_pend[1]) begin
        clr[1] = 1;
        if (m_count > 0) begin
          m_count--; m_dn_start = cyc; m_next_ok = cyc + PW + GP;
        end else m_drop = 1;
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      rise = m_rose[ch];
      if (rise && m_pend[ch] && !clr[ch]) m_drop = 1;
      m_pend[ch] = rise || (m_pend[ch] && !clr[ch]);
      m_rose[ch] = 0;
      if (m_s2[ch] != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == D) begin
          m_lvl[ch]  = !m_lvl[ch];
          m_run[ch]  = 0;
          m_rose[ch] = m_lvl[ch];
        end
      end else m_run[ch] = 0;
      m_s2[ch] = m_s1[ch];
      m_s1[ch] = raw[ch];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".up"},    32'(up_pulse),   int'(cyc >= m_up_start && cyc < m_up_start + PW));
    chk({tag, ".down"},  32'(down_pulse), int'(cyc >= m_dn_start && cyc < m_dn_start + PW));
    chk({tag, ".count"}, 32'(shadow_count), m_count);
    chk({tag, ".full"},  32'(full),       int'(m_count == MAXC));
    chk({tag, ".empty"}, 32'(empty),      int'(m_count == 0));
    chk({tag, ".drop"},  32'(drop_err),   int'(m_drop));
  endtask

  task automatic tick(input bit f, input bit b, input bit r);
    @(negedge clk);
    front = f; back = b; reset = r;
    @(posedge clk);
    if (!r) model_reset();
    else    model_step(f, b);
    #1;
    tick_no++;
    compare_all("cyc");
    if (up_pulse === 1'b1) begin n_up++; if (first_up < 0) first_up = tick_no; end
    if (down_pulse === 1'b1) begin n_dn++; if (first_dn < 0) first_dn = tick_no; end
    if (drop_err === 1'b1) n_drop++;
  endtask

  task automatic run(input bit f, input bit b, input bit r, input int n);
    repeat (n) tick(f, b, r);
  endtask

  task automatic clear_stats();
    first_up = -1; first_dn = -1; n_up = 0; n_dn = 0; n_drop = 0;
  endtask

  task automatic arrive();
    run(1, 0, 1, 8); run(0, 0, 1, 8);
  endtask

  task automatic depart();
    run(0, 1, 1, 8); run(0, 0, 1, 8);
  endtask

  // Called just after a checked edge: reset falls mid-cycle, outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all(tag);
  endtask

  int t0;
  bit seen;

  initial begin
    front = 1'b0; back = 1'b0; reset = 1'b1;
    model_reset();
    #3 reset = 1'b0;
    #1 compare_all("reset");
    run(0, 0, 0, 2);
    run(0, 0, 1, 3);

    // 1: single arrival, latency and width
    clear_stats();
    t0 = tick_no + 1;
    run(1, 0, 1, 20);
    chk("t1.latency", 32'(first_up - t0), 7);
    chk("t1.width", 32'(n_up), PW);
    chk("t1.count", 32'(shadow_count), 1);
    chk("t1.empty", 32'(empty), 0);
    run(0, 0, 1, 10);

    // 2: glitch shorter than the debounce window
    clear_stats();
    run(1, 0, 1, 3);
    run(0, 0, 1, 15);
    chk("t2.no_up", 32'(n_up), 0);
    chk("t2.no_drop", 32'(n_drop), 0);
    chk("t2.count", 32'(shadow_count), 1);

    // 3: fill to max, then one more arrival
    repeat (6) arrive();
    chk("t3.count7", 32'(shadow_count), 7);
    chk("t3.full", 32'(full), 1);
    clear_stats();
    arrive();
    chk("t3.no_up", 32'(n_up), 0);
    chk("t3.drop", 32'(n_drop), 1);
    chk("t3.stay7", 32'(shadow_count), 7);

    // 4: simultaneous arrival and departure at count 3
    repeat (4) depart();
    chk("t4.count3", 32'(shadow_count), 3);
    clear_stats();
    t0 = tick_no + 1;
    run(1, 1, 1, 8);
    run(0, 0, 1, 10);
    chk("t4.up_lat", 32'(first_up - t0), 7);
    chk("t4.up_to_dn", 32'(first_dn - first_up), PW + GP);
    chk("t4.up_w", 32'(n_up), PW);
    chk("t4.dn_w", 32'(n_dn), PW);
    chk("t4.count", 32'(shadow_count), 3);

    // 5: departure while empty
    repeat (3) depart();
    chk("t5.count0", 32'(shadow_count), 0);
    clear_stats();
    depart();
    chk("t5.no_dn", 32'(n_dn), 0);
    chk("t5.drop", 32'(n_drop), 1);
    chk("t5.empty", 32'(empty), 1);

    // 6: reset while up_pulse is high
    seen = 0;
    for (int i = 0; i < 15 && !seen; i++) begin
      tick(1, 0, 1);
      if (up_pulse === 1'b1) seen = 1;
    end
    chk("t6.up_seen", 32'(seen), 1);
    async_reset("t6.async");
    chk("t6.up_low", 32'(up_pulse), 0);
    chk("t6.count0", 32'(shadow_count), 0);
    run(0, 0, 0, 2);
    clear_stats();
    run(0, 0, 1, 20);
    chk("t6.quiet", 32'(n_up + n_dn), 0);

    // Randomised segments, occasionally with a reset mid-cycle.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 40) == 0) begin
        async_reset("rnd.async");
        run(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 2);
      end
      run(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1, $urandom_range(1, 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
